// File: rtl/jtkcpu_pshpul_ctrl.sv
// Push/pull sequencer for the register-file stack datapath: walks the register
// mask one byte at a time and runs the stack pointer and memory controls.
module jtkcpu_pshpul_ctrl #(
    parameter bit FAST_ACK = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       start,
    input  logic       pull,
    input  logic       ussel,
    input  logic [7:0] mask,
    input  logic       bus_ack,
    output logic [7:0] psh_sel,
    output logic       psh_hilon,
    output logic       psh_ussel,
    output logic       dec_us,
    output logic       pul_en,
    output logic       mem_we,
    output logic       mem_rd,
    output logic       busy,
    output logic       done,
    output logic       pul_pc,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PDEC = 3'd1,
        PWR  = 3'd2,
        PRD  = 3'd3,
        PUL  = 3'd4,
        FIN  = 3'd5
    } state_t;

    state_t     state_q;
    logic [7:0] rem_q;
    logic       pull_q;
    logic       ussel_q;
    logic       byte_q;     // 0: first byte of the current item, 1: second byte

    logic [7:0] hi_bit;
    logic [7:0] lo_bit;
    logic [7:0] cur;
    logic [7:0] rem_d;
    logic       is16;
    logic       last_byte;
    logic       ack_ok;
    logic       active;

    // Push walks PC down to CC, pull walks CC up to PC.
    always_comb begin
        hi_bit = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (rem_q[i]) begin
                hi_bit    = 8'd0;
                hi_bit[i] = 1'b1;
            end
        end
    end

    assign lo_bit    = rem_q & (~rem_q + 8'd1);
    assign cur       = pull_q ? lo_bit : hi_bit;
    assign is16      = |cur[7:4];
    assign last_byte = !is16 || byte_q;
    assign rem_d     = rem_q & ~cur;

    // mem_we/mem_rd is a request held steady until bus_ack is seen on a cen
    // cycle; the access completes on that cycle and the request drops next.
    assign ack_ok    = FAST_ACK ? 1'b1 : bus_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= 8'd0;
            pull_q  <= 1'b0;
            ussel_q <= 1'b0;
            byte_q  <= 1'b0;
        end else if (cen) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rem_q   <= mask;
                        pull_q  <= pull;
                        ussel_q <= ussel;
                        byte_q  <= 1'b0;
                        if (mask == 8'd0)
                            state_q <= FIN;
                        else if (pull)
                            state_q <= PRD;
                        else
                            state_q <= PDEC;
                    end
                end
                PDEC: state_q <= PWR;
                PWR: begin
                    if (ack_ok) begin
                        if (!last_byte) begin
                            byte_q  <= 1'b1;
                            state_q <= PDEC;
                        end else begin
                            byte_q  <= 1'b0;
                            rem_q   <= rem_d;
                            state_q <= (rem_d == 8'd0) ? FIN : PDEC;
                        end
                    end
                end
                PRD: begin
                    if (ack_ok)
                        state_q <= PUL;
                end
                PUL: begin
                    if (!last_byte) begin
                        byte_q  <= 1'b1;
                        state_q <= PRD;
                    end else begin
                        byte_q  <= 1'b0;
                        rem_q   <= rem_d;
                        state_q <= (rem_d == 8'd0) ? FIN : PRD;
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs decode only flops, so cen=0 holds every one of them.
    assign active    = (state_q == PDEC) || (state_q == PWR) ||
                       (state_q == PRD)  || (state_q == PUL);
    assign psh_sel   = active ? cur : 8'd0;
    assign psh_hilon = active && is16 && (pull_q ? !byte_q : byte_q);
    assign psh_ussel = ussel_q;
    assign dec_us    = (state_q == PDEC);
    assign mem_we    = (state_q == PWR);
    assign mem_rd    = (state_q == PRD);
    assign pul_en    = (state_q == PUL);
    assign pul_pc    = (state_q == PUL) && cur[7] && psh_hilon;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign dbg_state = state_q;

endmodule
